sram_like_slave: RTL and testbench

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

---
 rtl/sram_like_slave_pkg.sv | 36 +++
 rtl/sram_like_slave_sync_ram.sv | 36 +++
 rtl/sram_like_slave.sv | 184 ++++++++++++++++++
 tb/tb_sram_like_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like bus slave: bus widths, size
// encodings, default timing parameters and the byte-lane mask helper.
package sram_like_slave_pkg;

    // SRAM-like bus widths
    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;

    // Default geometry and timing
    localparam int DEF_DEPTH_LOG2      = 12;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_ADDR_DELAY      = 0;
    localparam int DEF_DATA_DELAY      = 1;

    // Access size encodings carried on sram_size
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALF     = 2'd1,
        SIZE_WORD     = 2'd2,
        SIZE_WORD_ALT = 2'd3
    } sram_size_e;

    // Byte-lane enables for an access; misaligned halves/words are
    // silently folded onto the aligned lanes.
    function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << addr_lo;
            SIZE_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_like_slave_sync_ram.sv
// Backing store: 2^DEPTH_LOG2 x 32-bit words, per-byte write enable,
// one-cycle registered read. Contents are never reset.
module sync_ram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [31:0]           rd_data_o,
    input  logic [3:0]            wr_be_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [31:0]           wr_data_i
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rd_data_q;

    // Byte-masked write port
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
                mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
    end

    // Registered read port; the word appears the cycle after rd_en_i
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus slave. Requests are accepted into an in-order queue and
// answered strictly in acceptance order, one response per cycle at most.
//
// Handshake: a request transfers on any cycle where sram_req and
// sram_addr_ok are both high; sram_data_ok pulses once per accepted
// request, oldest first, with sram_rdata valid only in that cycle.
//
// Timing model: an entry's age is 0 in its acceptance cycle and 1 in the
// first cycle it sits in the queue, so age equals cycles since acceptance.
// A read whose age already satisfies DATA_DELAY-1 in its acceptance cycle
// is issued to the RAM straight from the bus (bypass), which is how a read
// into an idle queue answers one cycle after acceptance.
//
// Reads are pipelined: while the head's RAM read is in flight, the next
// entry may issue its own read, giving one read response per cycle. A
// write only retires when no read response is due, so the RAM always sees
// operations in acceptance order and a later read sees earlier writes.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int ADDR_DELAY      = DEF_ADDR_DELAY,
    parameter int DATA_DELAY      = DEF_DATA_DELAY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sram_req,
    input  logic                   sram_wr,
    input  logic [1:0]             sram_size,
    input  logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_wdata,
    output logic                   sram_addr_ok,
    output logic [SRAM_DATA_W-1:0] sram_rdata,
    output logic                   sram_data_ok
);

    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int AGE_W  = $clog2(DATA_DELAY + 1);
    localparam int HOLD_W = $clog2(ADDR_DELAY + 1) + 1;

    typedef struct packed {
        logic                   wr;
        logic [DEPTH_LOG2-1:0]  idx;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [3:0]             mask;
    } entry_t;

    // Queue storage and bookkeeping
    entry_t           ent_q [MAX_OUTSTANDING];
    logic [AGE_W-1:0] age_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    // Head's RAM read was issued last cycle; its response is due now
    logic             rd_pend_q, rd_pend_d;

    // Service-side signals
    entry_t           in_ent;
    entry_t           cand;
    logic [AGE_W-1:0] cand_age;
    logic             cand_vld;
    logic [CNT_W-1:0] unserved;
    logic [PTR_W-1:0] issue_ptr;
    logic             accept;
    logic             rd_issue;
    logic             wr_fire;
    logic             pop;
    logic [31:0]      ram_rdata;
    logic [3:0]       ram_wr_be;

    // Address bits above the RAM index never affect the access
    logic unused_addr_bits;
    assign unused_addr_bits = ^sram_addr[SRAM_ADDR_W-1:DEPTH_LOG2+2];

    // Acceptance: room in the queue (start-of-cycle count) and req held long enough
    always_comb begin
        sram_addr_ok = !reset && sram_req
                       && (int'(count_q) < MAX_OUTSTANDING)
                       && (int'(hold_q) >= ADDR_DELAY);
        accept       = sram_req && sram_addr_ok;
    end

    // Capture the bus fields in queue-entry form
    always_comb begin
        in_ent.wr    = sram_wr;
        in_ent.idx   = sram_addr[DEPTH_LOG2+1:2];
        in_ent.wdata = sram_wdata;
        in_ent.mask  = byte_mask(sram_size, sram_addr[1:0]);
    end

    // Pick the oldest entry not yet sent to the RAM; fall back to the incoming request
    always_comb begin
        unserved  = count_q - CNT_W'(rd_pend_q);
        issue_ptr = head_q + PTR_W'(rd_pend_q);
        cand      = in_ent;
        cand_age  = '0;
        cand_vld  = accept;
        if (unserved != '0) begin
            cand     = ent_q[issue_ptr];
            cand_age = age_q[issue_ptr];
            cand_vld = 1'b1;
        end
    end

    // Decide this cycle's RAM operation and response
    always_comb begin
        rd_issue  = !reset && cand_vld && !cand.wr
                    && (int'(cand_age) >= DATA_DELAY - 1);
        wr_fire   = !reset && cand_vld && cand.wr && !rd_pend_q
                    && (int'(cand_age) >= DATA_DELAY);
        pop       = !reset && (rd_pend_q || wr_fire);
        ram_wr_be = wr_fire ? cand.mask : 4'b0000;
    end

    // Queue pointer, count, hold counter and read-pending next state
    always_comb begin
        count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
        head_d    = head_q + PTR_W'(pop);
        tail_d    = tail_q + PTR_W'(accept);
        rd_pend_d = rd_issue;
        hold_d    = hold_q;
        if (!sram_req || accept) begin
            hold_d = '0;
        end else if (int'(hold_q) < ADDR_DELAY) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Control state with synchronous reset; ages restart when a slot is filled
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (accept && (tail_q == PTR_W'(i))) begin
                    age_q[i] <= AGE_W'(1);
                end else if (int'(age_q[i]) < DATA_DELAY) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // Entry payload; only written on acceptance, which is blocked in reset
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_q[tail_q] <= in_ent;
        end
    end

    sync_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk_i     (clk),
        .rd_en_i   (rd_issue),
        .rd_idx_i  (cand.idx),
        .rd_data_o (ram_rdata),
        .wr_be_i   (ram_wr_be),
        .wr_idx_i  (cand.idx),
        .wr_data_i (cand.wdata)
    );

    // Response outputs; rdata is zero except on a read response
    always_comb begin
        sram_data_ok = pop;
        sram_rdata   = (!reset && rd_pend_q) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave. Instance A (defaults) runs directed and
// random traffic against a word-array memory model through an expected
// queue; instance B (DATA_DELAY=6) covers outstanding limits and reset
// mid-flight; instance C (ADDR_DELAY=3) covers the request hold delay.
module tb_sram_like_slave;

    logic clk = 1'b0;
    int   cyc = 0;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic        a_rst, a_req, a_wr, a_addr_ok, a_data_ok;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    // Instance B signals
    logic        b_rst, b_req, b_wr, b_addr_ok, b_data_ok;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;
    // Instance C signals
    logic        c_rst, c_req, c_wr, c_addr_ok, c_data_ok;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata, c_rdata;

    sram_like_slave #(.DEPTH_LOG2(12), .MAX_OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(1)) u_dut_a (
        .clk(clk), .reset(a_rst), .sram_req(a_req), .sram_wr(a_wr), .sram_size(a_size),
        .sram_addr(a_addr), .sram_wdata(a_wdata), .sram_addr_ok(a_addr_ok),
        .sram_rdata(a_rdata), .sram_data_ok(a_data_ok));

    sram_like_slave #(.DEPTH_LOG2(8), .MAX_OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(6)) u_dut_b (
        .clk(clk), .reset(b_rst), .sram_req(b_req), .sram_wr(b_wr), .sram_size(b_size),
        .sram_addr(b_addr), .sram_wdata(b_wdata), .sram_addr_ok(b_addr_ok),
        .sram_rdata(b_rdata), .sram_data_ok(b_data_ok));

    sram_like_slave #(.DEPTH_LOG2(8), .MAX_OUTSTANDING(4), .ADDR_DELAY(3), .DATA_DELAY(1)) u_dut_c (
        .clk(clk), .reset(c_rst), .sram_req(c_req), .sram_wr(c_wr), .sram_size(c_size),
        .sram_addr(c_addr), .sram_wdata(c_wdata), .sram_addr_ok(c_addr_ok),
        .sram_rdata(c_rdata), .sram_data_ok(c_data_ok));

    // Scoreboard state
    int          n_checks = 0;
    int          n_pass   = 0;
    int          idle_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_m [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: no DUT event within the cycle budget", name);
    endtask

    // Reference: bytes covered by an access of 1/2/4 bytes at the aligned-down position
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lo);
        int n, start;
        logic [31:0] r;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        start = int'(lo) - (int'(lo) % n);
        r     = old;
        for (int b = 0; b < 4; b++) begin
            if (b >= start && b < start + n) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Requests take effect in acceptance order, so the model updates on accept
    task automatic model_accept(input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wd);
        int idx;
        idx = int'(addr[5:2]);
        if (wr) begin
            mem_m[idx] = merge(mem_m[idx], wd, size, addr[1:0]);
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(mem_m[idx]);
        end
    endtask

    // Driver for A: present a request until accepted; leaves req high on return
    task automatic req_a(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, output int waited, output int acc_cyc);
        a_req = 1'b1; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wd;
        waited = 0; acc_cyc = -1;
        forever begin
            @(negedge clk);
            if (a_addr_ok) begin
                acc_cyc = cyc;
                model_accept(wr, size, addr, wd);
                @(posedge clk); #1;
                break;
            end
            waited++;
            @(posedge clk); #1;
            if (waited > 60) begin
                timeout("a_accept");
                break;
            end
        end
    endtask

    task automatic idle_a(input int n);
        a_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain_a();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
        if (exp_q.size() != 0) timeout("a_drain");
    endtask

    // Monitor for A: every response is matched against the oldest expectation
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (!a_rst) begin
            if (a_data_ok) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_unexpected_data_ok: got rdata %h with nothing outstanding", a_rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("a_resp", a_rdata, exp_v);
                end
            end else if (a_rdata !== 32'h0) begin
                idle_bad++;
            end
        end
    end

    // Driver for B: one word access, returns the response data and its latency
    task automatic b_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata, output int lat);
        int  acc_c;
        bit  got;
        b_req = 1'b1; b_wr = wr; b_size = 2'd2; b_addr = addr; b_wdata = wd;
        got = 0; acc_c = 0; lat = -1; rdata = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_addr_ok) begin acc_c = cyc; got = 1; end
            @(posedge clk); #1;
            if (got) break;
        end
        b_req = 1'b0;
        if (got) begin
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (b_data_ok) begin lat = cyc - acc_c; rdata = b_rdata; break; end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          w, ac, acw, acr, first, na, nr, dok;
        logic        acc;
        logic [31:0] rd;
        int          lat;
        int          acc_b[5];
        int          rsp_cyc[5];
        logic [31:0] rsp_dat[5];

        a_rst = 1; b_rst = 1; c_rst = 1;
        a_req = 1; a_wr = 0; a_size = 2; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_size = 2; b_addr = 0; b_wdata = 0;
        c_req = 0; c_wr = 0; c_size = 2; c_addr = 0; c_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_addr_ok_low", {31'b0, a_addr_ok}, 32'h0);
        @(posedge clk); #1;
        a_rst = 0; b_rst = 0; c_rst = 0; a_req = 0;
        @(negedge clk);
        check("reset_data_ok_low", {31'b0, a_data_ok}, 32'h0);
        check("reset_rdata_zero", a_rdata, 32'h0);
        @(posedge clk); #1;

        // A: known contents for the 16 words the random traffic touches
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 32'h0;
            req_a(1'b1, 2'd2, 32'(i * 4), $urandom, w, ac);
        end
        idle_a(1);
        drain_a();
        idle_a(2);

        // A: word write then read of 0x10
        req_a(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, w, ac);
        check("wr_addr_ok_same_cycle", 32'(w), 32'h0);
        a_req = 0;
        @(negedge clk);
        check("wr_data_ok_next_cycle", {31'b0, a_data_ok}, 32'h1);
        check("wr_rdata_zero", a_rdata, 32'h0);
        @(posedge clk); #1;
        idle_a(1);
        req_a(1'b0, 2'd2, 32'h10, 32'h0, w, ac);
        check("rd_addr_ok_same_cycle", 32'(w), 32'h0);
        a_req = 0;
        @(negedge clk);
        check("rd_data_ok_next_cycle", {31'b0, a_data_ok}, 32'h1);
        check("rd_deadbeef", a_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        idle_a(1);

        // A: byte write to 0x13 merges into the top lane
        req_a(1'b1, 2'd0, 32'h13, 32'hAA000000, w, ac);
        idle_a(2);
        req_a(1'b0, 2'd2, 32'h10, 32'h0, w, ac);
        a_req = 0;
        @(negedge clk);
        check("rd_byte_merge", a_rdata, 32'hAAADBEEF);
        @(posedge clk); #1;
        idle_a(2);

        // A: read of 0x20 accepted in the cycle the head write to 0x20 retires
        req_a(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, w, acw);
        req_a(1'b0, 2'd2, 32'h20, 32'h0, w, acr);
        a_req = 0;
        check("raw_accept_on_retire", 32'(acr - acw), 32'h1);
        dok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_data_ok) begin check("raw_new_data", a_rdata, 32'hCAFEF00D); dok = 1; break; end
        end
        if (dok == 0) timeout("raw_data_ok");
        @(posedge clk); #1;
        idle_a(1);

        // A: random mix of sizes, lanes, gaps and queue-full stalls
        for (int n = 0; n < 300; n++) begin
            req_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 63)), $urandom, w, ac);
            if ($urandom_range(0, 2) == 0) idle_a($urandom_range(1, 3));
        end
        idle_a(1);
        drain_a();

        // B: seed words 0..4
        for (int i = 0; i < 5; i++) begin
            b_access(1'b1, 32'(i * 4), 32'h1000 + 32'(i), rd, lat);
        end

        // B: five reads held back-to-back against four slots
        na = 0; nr = 0;
        b_req = 1; b_wr = 0; b_size = 2; b_addr = 0;
        for (int i = 0; i < 60 && nr < 5; i++) begin
            @(negedge clk);
            if (b_data_ok) begin rsp_cyc[nr] = cyc; rsp_dat[nr] = b_rdata; nr++; end
            acc = b_req && b_addr_ok;
            if (acc) begin acc_b[na] = cyc; na++; end
            @(posedge clk); #1;
            if (acc) begin
                if (na == 5) b_req = 0;
                else b_addr = 32'(na * 4);
            end
        end
        b_req = 0;
        check("b_accepts", 32'(na), 32'd5);
        check("b_responses", 32'(nr), 32'd5);
        if (na == 5 && nr == 5) begin
            for (int i = 1; i < 4; i++) check("b_consecutive_accept", 32'(acc_b[i] - acc_b[0]), 32'(i));
            check("b_first_latency", 32'(rsp_cyc[0] - acc_b[0]), 32'd6);
            check("b_fifth_after_first_resp", 32'(acc_b[4] - rsp_cyc[0]), 32'd1);
            for (int i = 1; i < 4; i++) check("b_resp_per_cycle", 32'(rsp_cyc[i] - rsp_cyc[0]), 32'(i));
            for (int i = 0; i < 5; i++) check("b_resp_order", rsp_dat[i], 32'h1000 + 32'(i));
        end
        repeat (3) begin @(posedge clk); #1; end

        // B: reset with three reads outstanding
        na = 0;
        b_req = 1; b_wr = 0; b_size = 2; b_addr = 0;
        for (int i = 0; i < 20 && na < 3; i++) begin
            @(negedge clk);
            acc = b_addr_ok;
            @(posedge clk); #1;
            if (acc) begin na++; b_addr = 32'(na * 4); end
        end
        check("b_pre_reset_accepts", 32'(na), 32'd3);
        b_rst = 1;
        @(negedge clk);
        check("b_addr_ok_in_reset", {31'b0, b_addr_ok}, 32'h0);
        @(posedge clk); #1;
        b_rst = 0; b_req = 0;
        @(negedge clk);
        check("b_rdata_after_reset", b_rdata, 32'h0);
        dok = 0;
        for (int i = 0; i < 15; i++) begin
            if (b_data_ok) dok++;
            @(negedge clk);
        end
        check("b_no_data_ok_after_reset", 32'(dok), 32'h0);
        @(posedge clk); #1;
        b_access(1'b0, 32'h0C, 32'h0, rd, lat);
        check("b_post_reset_read", rd, 32'h1003);
        check("b_post_reset_latency", 32'(lat), 32'd6);

        // C: addr_ok appears in the 4th cycle of a held req
        c_req = 1; c_wr = 1; c_size = 2; c_addr = 0; c_wdata = 32'h5A5A5A5A;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (c_addr_ok) first = i;
            @(posedge clk); #1;
            if (first >= 0) break;
        end
        check("c_first_addr_ok_cycle", 32'(first), 32'd4);
        c_req = 0;
        repeat (2) begin @(posedge clk); #1; end

        // C: two cycles of req, one cycle dropped, then the count restarts
        c_req = 1;
        @(negedge clk);
        check("c_partial_hold_1", {31'b0, c_addr_ok}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("c_partial_hold_2", {31'b0, c_addr_ok}, 32'h0);
        @(posedge clk); #1;
        c_req = 0;
        @(posedge clk); #1;
        c_req = 1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (c_addr_ok) first = i;
            @(posedge clk); #1;
            if (first >= 0) break;
        end
        check("c_restart_addr_ok_cycle", 32'(first), 32'd4);
        c_req = 0;
        repeat (3) begin @(posedge clk); #1; end

        check("a_idle_rdata_zero", 32'(idle_bad), 32'h0);
        check("a_expected_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
